// File: rtl/cordic_pkg.sv
// Shared constants, arctangent table, FSM state type and gain-compensation
// shift list for the CORDIC vectoring engine.
package cordic_pkg;

    localparam int PHI_W = 13;

    // Quarter-turn pre-rotation angles in phi LSBs (pi/4096)
    localparam logic signed [PHI_W-1:0] PRE_ROT_POS = 13'sd2048;
    localparam logic signed [PHI_W-1:0] PRE_ROT_NEG = -13'sd2048;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROT,
        S_COMP,
        S_DONE
    } state_t;

    // K ~= x/2 + x/8 - x/64 - x/512 - x/4096
    localparam int COMP_TERMS = 5;
    localparam int COMP_SHIFT [COMP_TERMS] = '{1, 3, 6, 9, 12};
    localparam logic [COMP_TERMS-1:0] COMP_NEG = 5'b11100;

    function automatic logic signed [PHI_W-1:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    return 13'sd1024;
            4'd1:    return 13'sd605;
            4'd2:    return 13'sd319;
            4'd3:    return 13'sd162;
            4'd4:    return 13'sd81;
            4'd5:    return 13'sd41;
            4'd6:    return 13'sd20;
            4'd7:    return 13'sd10;
            4'd8:    return 13'sd5;
            4'd9:    return 13'sd3;
            4'd10:   return 13'sd1;
            4'd11:   return 13'sd1;
            default: return 13'sd0;
        endcase
    endfunction

endpackage

// File: rtl/vec_micro_rot.sv
// One combinational CORDIC vectoring micro-rotation: drives y toward zero
// and accumulates the applied angle into z.
module vec_micro_rot
    import cordic_pkg::*;
#(
    parameter int XW = 18
) (
    input  logic [XW-1:0]    x,
    input  logic [XW-1:0]    y,
    input  logic [PHI_W-1:0] z,
    input  logic [3:0]       i,
    output logic [XW-1:0]    x_next,
    output logic [XW-1:0]    y_next,
    output logic [PHI_W-1:0] z_next
);

    logic signed [XW-1:0]    xs, ys, x_sh, y_sh;
    logic signed [PHI_W-1:0] zs, atan_i;

    assign xs     = $signed(x);
    assign ys     = $signed(y);
    assign zs     = $signed(z);
    assign x_sh   = xs >>> i;
    assign y_sh   = ys >>> i;
    assign atan_i = atan_lut(i);

    always_comb begin
        if (!ys[XW-1]) begin
            x_next = xs + y_sh;
            y_next = ys - x_sh;
            z_next = zs + atan_i;
        end else begin
            x_next = xs - y_sh;
            y_next = ys + x_sh;
            z_next = zs - atan_i;
        end
    end

endmodule

// File: rtl/cordic_vector_engine.sv
// Iterative CORDIC vectoring engine: returns angle and magnitude of (x, y).
// Define CORDIC_GAIN_COMP_EN to add a COMP state that scales the magnitude by K.
module cordic_vector_engine
    import cordic_pkg::*;
#(
    parameter int ITER = 13,
    parameter int W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x_in,
    input  logic [W-1:0]     y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PHI_W-1:0] phi_out,
    output logic [W-1:0]     mag_out
);

    localparam int XW = W + 2;

    state_t                  state;
    logic [3:0]              cnt;
    logic signed [XW-1:0]    x_p0, y_p0;
    logic signed [PHI_W-1:0] z_p0;
    logic                    zero_p0;

    logic signed [XW-1:0]    x_ext, y_ext, x_pre, y_pre;
    logic signed [PHI_W-1:0] z_pre;
    logic [XW-1:0]           x_nx, y_nx;
    logic [PHI_W-1:0]        z_nx;
    logic                    xfer;

`ifdef CORDIC_GAIN_COMP_EN
    function automatic logic [W-1:0] gain_comp(input logic signed [XW-1:0] v);
        logic signed [XW-1:0] acc;
        acc = '0;
        for (int k = 0; k < COMP_TERMS; k++) begin
            if (COMP_NEG[k]) acc = acc - (v >>> COMP_SHIFT[k]);
            else             acc = acc + (v >>> COMP_SHIFT[k]);
        end
        return acc[W-1:0];
    endfunction
`else
    function automatic logic [W-1:0] sat_mag(input logic signed [XW-1:0] v);
        if (v[XW-1])                                 return '0;
        else if (v > $signed({2'b00, {W{1'b1}}}))    return '1;
        else                                         return v[W-1:0];
    endfunction
`endif

    assign xfer  = in_valid && in_ready;
    assign x_ext = {{2{x_in[W-1]}}, x_in};
    assign y_ext = {{2{y_in[W-1]}}, y_in};

    // Fold the left half-plane onto the right with a +/-90 degree turn
    always_comb begin
        x_pre = x_ext;
        y_pre = y_ext;
        z_pre = '0;
        if (x_ext[XW-1]) begin
            if (!y_ext[XW-1]) begin
                x_pre = y_ext;
                y_pre = -x_ext;
                z_pre = PRE_ROT_POS;
            end else begin
                x_pre = -y_ext;
                y_pre = x_ext;
                z_pre = PRE_ROT_NEG;
            end
        end
    end

    vec_micro_rot #(.XW(XW)) u_rot (
        .x      (x_p0),
        .y      (y_p0),
        .z      (z_p0),
        .i      (cnt),
        .x_next (x_nx),
        .y_next (y_nx),
        .z_next (z_nx)
    );

    // p0: working vector, loaded on transfer and updated each ROT cycle
    always_ff @(posedge clk) begin
        if (state == S_IDLE && xfer) begin
            x_p0    <= x_pre;
            y_p0    <= y_pre;
            z_p0    <= z_pre;
            zero_p0 <= (x_in == '0) && (y_in == '0);
        end else if (state == S_ROT) begin
            x_p0 <= $signed(x_nx);
            y_p0 <= $signed(y_nx);
            z_p0 <= $signed(z_nx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            phi_out   <= '0;
            mag_out   <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        state    <= S_ROT;
                        in_ready <= 1'b0;
                        cnt      <= '0;
                    end
                end
                S_ROT: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
                        state <= S_COMP;
`else
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        phi_out   <= zero_p0 ? '0 : z_nx;
                        mag_out   <= zero_p0 ? '0 : sat_mag($signed(x_nx));
`endif
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                S_COMP: begin
                    state     <= S_DONE;
                    out_valid <= 1'b1;
                    phi_out   <= zero_p0 ? '0 : z_p0;
                    mag_out   <= zero_p0 ? '0 : gain_comp(x_p0);
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vector_engine.sv
// Directed/scoreboard bench for cordic_vector_engine, raw or with CORDIC_GAIN_COMP_EN.
module tb_cordic_vector_engine;

    localparam int ITER = 13;
    localparam int W    = 16;
    localparam real PI  = 3.141592653589793;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int  LAT  = ITER + 2;
    localparam bit  COMP = 1'b1;
    localparam real GAIN = 1.646760258 * 0.607177734375;
`else
    localparam int  LAT  = ITER + 1;
    localparam bit  COMP = 1'b0;
    localparam real GAIN = 1.646760258;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  x_in = '0;
    logic [W-1:0]  y_in = '0;
    logic          in_ready;
    logic          out_valid;
    logic [12:0]   phi_out;
    logic [W-1:0]  mag_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int xfer_cyc = 0;

    typedef struct {
        string tag;
        real   phi;
        int    phi_tol;
        int    mag;
        int    mag_tol;
    } exp_t;

    exp_t sb[$];

    cordic_vector_engine #(.ITER(ITER), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .phi_out   (phi_out),
        .mag_out   (mag_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input longint got, input longint want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic check_near(input string tag, input real got, input real want, input int tol);
        real d;
        total++;
        d = got - want;
        if (d < 0.0) d = -d;
        assert (d <= real'(tol))
        else begin
            bad++;
            $error("FAIL %s observed=%0.1f expected=%0.1f tol=%0d", tag, got, want, tol);
        end
    endtask

    task automatic push(input string tag, input real phi, input int ptol, input int mag, input int mtol);
        exp_t e;
        e.tag = tag; e.phi = phi; e.phi_tol = ptol; e.mag = mag; e.mag_tol = mtol;
        sb.push_back(e);
    endtask

    task automatic push_model(input string tag, input int xv, input int yv, input int ptol, input int mtol);
        real p, m;
        p = $atan2(real'(yv), real'(xv)) * 4096.0 / PI;
        m = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv)) * GAIN;
        if (m > 65535.0) m = 65535.0;
        push(tag, p, ptol, int'($floor(m + 0.5)), mtol);
    endtask

    task automatic drive(input int xv, input int yv);
        int n;
        @(negedge clk);
        x_in = xv[W-1:0];
        y_in = yv[W-1:0];
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq("handshake", longint'(in_ready), 1);
        xfer_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input bit chk_lat);
        int   n;
        exp_t e;
        real  p, d;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("out_valid_seen", longint'(out_valid), 1);
        if (out_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            if (chk_lat) check_eq({e.tag, "_latency"}, longint'(cyc - xfer_cyc), LAT);
            p = real'(int'($signed(phi_out)));
            d = p - e.phi;
            while (d > 4096.0)  d -= 8192.0;
            while (d < -4096.0) d += 8192.0;
            check_near({e.tag, "_phi"}, e.phi + d, e.phi, e.phi_tol);
            check_near({e.tag, "_mag"}, real'(int'(mag_out)), real'(e.mag), e.mag_tol);
            if (out_ready === 1'b1) begin
                @(negedge clk);
                check_eq({e.tag, "_ready_after"}, longint'(in_ready), 1);
            end
        end
    endtask

    initial begin
        logic [12:0]  phi_hold;
        logic [W-1:0] mag_hold;
        int           seen;
        int           rx, ry;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", longint'(in_ready), 1);
        check_eq("rst_out_valid", longint'(out_valid), 0);
        check_eq("rst_phi", longint'(phi_out), 0);
        check_eq("rst_mag", longint'(mag_out), 0);
        rst = 1'b0;

        push("x_axis", 0.0, 2, COMP ? 16384 : 26981, 3);
        drive(16384, 0);
        collect(1'b1);

        push_model("y_axis", 0, 16384, 2, 6);
        sb[sb.size()-1].phi = 2048.0;
        drive(0, 16384);
        collect(1'b1);

        push("neg_x", 4096.0, 2, COMP ? 16384 : 26981, 6);
        drive(-16384, 0);
        collect(1'b1);

        push_model("q3_diag", -16384, -16384, 2, 6);
        sb[sb.size()-1].phi = -3072.0;
        drive(-16384, -16384);
        collect(1'b1);

        push("zero", 0.0, 0, 0, 0);
        drive(0, 0);
        collect(1'b1);

        push_model("sat", 32767, 32767, 3, COMP ? 6 : 0);
        drive(32767, 32767);
        collect(1'b1);

        // Stall in DONE while in_valid stays high with a different operand
        out_ready = 1'b0;
        push_model("stall", 12000, -5000, 4, 6);
        drive(12000, -5000);
        x_in = 16'd3000;
        y_in = 16'd3000;
        in_valid = 1'b1;
        seen = 0;
        while (out_valid !== 1'b1 && seen < 100) begin
            @(negedge clk);
            seen++;
        end
        phi_hold = phi_out;
        mag_hold = mag_out;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("stall_valid", longint'(out_valid), 1);
            check_eq("stall_in_ready", longint'(in_ready), 0);
            check_eq("stall_phi", longint'(phi_out), longint'(phi_hold));
            check_eq("stall_mag", longint'(mag_out), longint'(mag_hold));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        collect(1'b0);

        // Reset during ROT cycle 4 discards the operation
        drive(10000, 10000);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_in_ready", longint'(in_ready), 1);
        check_eq("midrst_out_valid", longint'(out_valid), 0);
        check_eq("midrst_phi", longint'(phi_out), 0);
        check_eq("midrst_mag", longint'(mag_out), 0);
        seen = 0;
        for (int k = 0; k < 2 * ITER; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        check_eq("midrst_no_result", longint'(seen), 0);

        for (int k = 0; k < 6; k++) begin
            rx = int'($urandom_range(40000, 0)) - 20000;
            ry = int'($urandom_range(40000, 0)) - 20000;
            if (ry == 0) ry = 1;
            push_model("rand", rx, ry, 4, 6);
            drive(rx, ry);
            collect(1'b1);
        end

        check_eq("sb_empty", longint'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
